nx_node_inbound: RTL
====================

// Module: nx_node_inbound
// PURPOSE
//   Inbound message stage of a mesh node: accepts messages arriving from the router, decodes those
//   addressed to this node into I/O-mapping, signal-state, instruction-load and trigger strobes
//   that drive nx_node_control and the instruction store, and forwards non-local and broadcast
//   messages to the bypass port. Local decode never back-pressures; only the bypass path can stall.
// PARAMETERS
//   STREAM_WIDTH    32  message width
//   ADDR_ROW_WIDTH   4  node row address width
//   ADDR_COL_WIDTH   4  node column address width
//   COMMAND_WIDTH    2  command field width
//   INPUTS           8  input slots per node
//   OUTPUTS          8  output slots per node
// PORTS
//   clk_i                clock    in   1    single clock domain
//   rst_i                reset    in   1    asynchronous, active-low reset
//   node_row_i           in   ADDR_ROW_WIDTH  this node's row
//   node_col_i           in   ADDR_COL_WIDTH  this node's column
//   msg_data_i           in   STREAM_WIDTH    inbound message
//   msg_valid_i          in   1               inbound valid
//   msg_ready_o          out  1               inbound ready
//   bypass_data_o        out  STREAM_WIDTH    forwarded message
//   bypass_valid_o       out  1               forwarded valid
//   bypass_ready_i       in   1               forwarded ready
//   map_io_o, map_input_o, map_remote_row_o, map_remote_col_o, map_remote_idx_o,
//   map_slot_o, map_broadcast_o, map_seq_o, map_valid_o    out  I/O mapping strobe to nx_node_control
//   signal_remote_row_o, signal_remote_col_o, signal_remote_idx_o,
//   signal_state_o, signal_valid_o                          out  signal-state strobe to nx_node_control
//   instr_data_o         out  PAYLOAD_WIDTH   instruction word; instr_valid_o out 1 strobe
//   trigger_o            out  1               external trigger pulse to nx_node_control
// BEHAVIOUR
//   Format: [31] bc, [30:27] row, [26:23] col, [22:21] cmd, [20:0] payload (PAYLOAD_WIDTH=21).
//   cmd: 0 LOAD_INSTR payload=instr; 1 MAP_IO payload={io[2:0],input,row,col,idx[2:0],slot,bc,seq,3'b0};
//        2 SIG_STATE payload={row,col,idx[2:0],state,9'b0}; 3 CONTROL payload[0]=trigger, rest ignored.
//   Local = bc || (row==node_row_i && col==node_col_i). Forward = bc || !local-address-match.
//   Single holding register (hold_q, hold_valid_q). Handshake on msg_valid_i && msg_ready_o at edge T.
//   msg_ready_o = !hold_valid_q || hold drains this cycle. Drains when: local-only -> always;
//     forward needed -> bypass slot empty or bypass_ready_i high this cycle. Back-to-back at full rate.
//   Decode: at edge T+1 (hold drain edge) exactly one of map/signal/instr valid or trigger_o asserts,
//     registered, high for exactly one cycle; field outputs registered alongside, hold value otherwise.
//   CONTROL with payload[0]=0: no strobe. Broadcast: local strobe AND bypass copy, data unchanged;
//     hold drains only when bypass accepts, local strobe fires on that same drain edge (never twice).
//   Bypass register: bypass_valid_o held, data stable, until bypass_ready_i; then reload same edge if
//     hold drains into it, else clear. Forwarded data is bit-identical to input.
//   Latency: local strobe 2 edges after accept-edge-relative (T accept, T+1 strobe visible); bypass
//     likewise visible after T+1 if slot free.
//   Ordering: messages leave hold strictly in arrival order; a stalled forward blocks later locals.
//   Reset (async assert, sync deassert): hold/bypass cleared, all valids/strobes 0, fields 0,
//     msg_ready_o 1 after deassert. Reset mid-operation discards held and bypass messages.
// TESTING
//   Node (2,3): accept {0,2,3,SIG,1,1,5,1,0} -> next cycle signal_valid_o=1 row=1 col=1 idx=5 state=1, 1 cycle.
//   MAP_IO io=4 input=1 row=6 col=7 idx=2 seq=1 -> map_valid_o pulse with those fields; no bypass.
//   Non-local row=5 with bypass_ready_i=0 for 5 cycles -> bypass_valid_o held, msg_ready_o=0 after
//     second message, no local strobe; release -> both forwarded in order, data identical.
//   Broadcast SIG_STATE, bypass_ready_i=1 -> one signal_valid_o pulse and one bypass transfer.
//   4 back-to-back local messages, continuous valid -> msg_ready_o stays 1, 4 consecutive strobes.
//   rst_i low while bypass stalled -> bypass_valid_o=0, strobes 0; message not reissued after reset.

Source files
------------

// File: rtl/nx_node_inbound.sv
// Inbound message stage of a mesh node: decodes locally addressed messages into
// control strobes and forwards non-local and broadcast messages to the bypass port.
module nx_node_inbound #(
    parameter int STREAM_WIDTH   = 32,
    parameter int ADDR_ROW_WIDTH = 4,
    parameter int ADDR_COL_WIDTH = 4,
    parameter int COMMAND_WIDTH  = 2,
    parameter int INPUTS         = 8,
    parameter int OUTPUTS        = 8,
    localparam int PAYLOAD_WIDTH = STREAM_WIDTH - 1 - ADDR_ROW_WIDTH - ADDR_COL_WIDTH - COMMAND_WIDTH,
    localparam int IDX_WIDTH     = $clog2(INPUTS),
    localparam int IO_WIDTH      = $clog2(OUTPUTS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDR_ROW_WIDTH-1:0] node_row_i,
    input  logic [ADDR_COL_WIDTH-1:0] node_col_i,
    input  logic [STREAM_WIDTH-1:0]   msg_data_i,
    input  logic                      msg_valid_i,
    output logic                      msg_ready_o,
    output logic [STREAM_WIDTH-1:0]   bypass_data_o,
    output logic                      bypass_valid_o,
    input  logic                      bypass_ready_i,
    output logic [IO_WIDTH-1:0]       map_io_o,
    output logic                      map_input_o,
    output logic [ADDR_ROW_WIDTH-1:0] map_remote_row_o,
    output logic [ADDR_COL_WIDTH-1:0] map_remote_col_o,
    output logic [IDX_WIDTH-1:0]      map_remote_idx_o,
    output logic                      map_slot_o,
    output logic                      map_broadcast_o,
    output logic                      map_seq_o,
    output logic                      map_valid_o,
    output logic [ADDR_ROW_WIDTH-1:0] signal_remote_row_o,
    output logic [ADDR_COL_WIDTH-1:0] signal_remote_col_o,
    output logic [IDX_WIDTH-1:0]      signal_remote_idx_o,
    output logic                      signal_state_o,
    output logic                      signal_valid_o,
    output logic [PAYLOAD_WIDTH-1:0]  instr_data_o,
    output logic                      instr_valid_o,
    output logic                      trigger_o
);

    typedef enum logic [1:0] {
        CMD_LOAD_INSTR = 2'd0,
        CMD_MAP_IO     = 2'd1,
        CMD_SIG_STATE  = 2'd2,
        CMD_CONTROL    = 2'd3
    } cmd_e;

    // Message header positions (MSB first: bc, row, col, cmd, payload).
    localparam int HDR_BC  = STREAM_WIDTH - 1;
    localparam int HDR_ROW = HDR_BC - 1;
    localparam int HDR_COL = HDR_ROW - ADDR_ROW_WIDTH;

    // MAP_IO payload field MSB positions.
    localparam int MAP_IO   = PAYLOAD_WIDTH - 1;
    localparam int MAP_IN   = MAP_IO - IO_WIDTH;
    localparam int MAP_ROW  = MAP_IN - 1;
    localparam int MAP_COL  = MAP_ROW - ADDR_ROW_WIDTH;
    localparam int MAP_IDX  = MAP_COL - ADDR_COL_WIDTH;
    localparam int MAP_SLOT = MAP_IDX - IDX_WIDTH;
    localparam int MAP_BC   = MAP_SLOT - 1;
    localparam int MAP_SEQ  = MAP_BC - 1;

    // SIG_STATE payload field MSB positions.
    localparam int SIG_ROW   = PAYLOAD_WIDTH - 1;
    localparam int SIG_COL   = SIG_ROW - ADDR_ROW_WIDTH;
    localparam int SIG_IDX   = SIG_COL - ADDR_COL_WIDTH;
    localparam int SIG_STATE = SIG_IDX - IDX_WIDTH;

    logic [STREAM_WIDTH-1:0]   r_hold_data;
    logic                      r_hold_valid;
    logic [STREAM_WIDTH-1:0]   r_byp_data;
    logic                      r_byp_valid;

    logic                      w_hold_bc;
    logic [ADDR_ROW_WIDTH-1:0] w_hold_row;
    logic [ADDR_COL_WIDTH-1:0] w_hold_col;
    cmd_e                      w_hold_cmd;
    logic [PAYLOAD_WIDTH-1:0]  w_payload;
    logic                      w_addr_match;
    logic                      w_local;
    logic                      w_forward;
    logic                      w_drain;
    logic                      w_accept;
    logic                      w_fire_map;
    logic                      w_fire_sig;
    logic                      w_fire_instr;
    logic                      w_fire_trig;

    logic [IO_WIDTH-1:0]       r_map_io;
    logic                      r_map_input;
    logic [ADDR_ROW_WIDTH-1:0] r_map_row;
    logic [ADDR_COL_WIDTH-1:0] r_map_col;
    logic [IDX_WIDTH-1:0]      r_map_idx;
    logic                      r_map_slot;
    logic                      r_map_bc;
    logic                      r_map_seq;
    logic                      r_map_valid;
    logic [ADDR_ROW_WIDTH-1:0] r_sig_row;
    logic [ADDR_COL_WIDTH-1:0] r_sig_col;
    logic [IDX_WIDTH-1:0]      r_sig_idx;
    logic                      r_sig_state;
    logic                      r_sig_valid;
    logic [PAYLOAD_WIDTH-1:0]  r_instr_data;
    logic                      r_instr_valid;
    logic                      r_trigger;

    assign w_hold_bc  = r_hold_data[HDR_BC];
    assign w_hold_row = r_hold_data[HDR_ROW -: ADDR_ROW_WIDTH];
    assign w_hold_col = r_hold_data[HDR_COL -: ADDR_COL_WIDTH];
    assign w_hold_cmd = cmd_e'(r_hold_data[PAYLOAD_WIDTH +: COMMAND_WIDTH]);
    assign w_payload  = r_hold_data[PAYLOAD_WIDTH-1:0];

    assign w_addr_match = (w_hold_row == node_row_i) && (w_hold_col == node_col_i);
    assign w_local      = w_hold_bc || w_addr_match;
    assign w_forward    = w_hold_bc || !w_addr_match;

    // A forwarding message may only leave hold when the bypass slot is free or
    // emptying this cycle; a broadcast's local strobe waits for that same edge.
    assign w_drain     = r_hold_valid && (!w_forward || !r_byp_valid || bypass_ready_i);
    assign msg_ready_o = !r_hold_valid || w_drain;
    assign w_accept    = msg_valid_i && msg_ready_o;

    // NOTE: every always_comb output gets a default before the case so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_fire_map   = 1'b0;
        w_fire_sig   = 1'b0;
        w_fire_instr = 1'b0;
        w_fire_trig  = 1'b0;
        if (w_drain && w_local) begin
            case (w_hold_cmd)
                CMD_LOAD_INSTR: w_fire_instr = 1'b1;
                CMD_MAP_IO:     w_fire_map   = 1'b1;
                CMD_SIG_STATE:  w_fire_sig   = 1'b1;
                CMD_CONTROL:    w_fire_trig  = w_payload[0];
                default:        ;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_accept) begin
            r_hold_data  <= msg_data_i;
            r_hold_valid <= 1'b1;
        end else if (w_drain) begin
            r_hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_byp_data  <= '0;
            r_byp_valid <= 1'b0;
        end else if (w_drain && w_forward) begin
            r_byp_data  <= r_hold_data;
            r_byp_valid <= 1'b1;
        end else if (r_byp_valid && bypass_ready_i) begin
            r_byp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_map_valid   <= 1'b0;
            r_sig_valid   <= 1'b0;
            r_instr_valid <= 1'b0;
            r_trigger     <= 1'b0;
        end else begin
            r_map_valid   <= w_fire_map;
            r_sig_valid   <= w_fire_sig;
            r_instr_valid <= w_fire_instr;
            r_trigger     <= w_fire_trig;
        end
    end

    // NOTE: field registers are reset too so downstream never sees X on the
    // buses, even though they are only meaningful alongside their strobe.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_map_io    <= '0;
            r_map_input <= 1'b0;
            r_map_row   <= '0;
            r_map_col   <= '0;
            r_map_idx   <= '0;
            r_map_slot  <= 1'b0;
            r_map_bc    <= 1'b0;
            r_map_seq   <= 1'b0;
        end else if (w_fire_map) begin
            r_map_io    <= w_payload[MAP_IO -: IO_WIDTH];
            r_map_input <= w_payload[MAP_IN];
            r_map_row   <= w_payload[MAP_ROW -: ADDR_ROW_WIDTH];
            r_map_col   <= w_payload[MAP_COL -: ADDR_COL_WIDTH];
            r_map_idx   <= w_payload[MAP_IDX -: IDX_WIDTH];
            r_map_slot  <= w_payload[MAP_SLOT];
            r_map_bc    <= w_payload[MAP_BC];
            r_map_seq   <= w_payload[MAP_SEQ];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sig_row   <= '0;
            r_sig_col   <= '0;
            r_sig_idx   <= '0;
            r_sig_state <= 1'b0;
        end else if (w_fire_sig) begin
            r_sig_row   <= w_payload[SIG_ROW -: ADDR_ROW_WIDTH];
            r_sig_col   <= w_payload[SIG_COL -: ADDR_COL_WIDTH];
            r_sig_idx   <= w_payload[SIG_IDX -: IDX_WIDTH];
            r_sig_state <= w_payload[SIG_STATE];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_instr_data <= '0;
        end else if (w_fire_instr) begin
            r_instr_data <= w_payload;
        end
    end

    assign bypass_data_o       = r_byp_data;
    assign bypass_valid_o      = r_byp_valid;
    assign map_io_o            = r_map_io;
    assign map_input_o         = r_map_input;
    assign map_remote_row_o    = r_map_row;
    assign map_remote_col_o    = r_map_col;
    assign map_remote_idx_o    = r_map_idx;
    assign map_slot_o          = r_map_slot;
    assign map_broadcast_o     = r_map_bc;
    assign map_seq_o           = r_map_seq;
    assign map_valid_o         = r_map_valid;
    assign signal_remote_row_o = r_sig_row;
    assign signal_remote_col_o = r_sig_col;
    assign signal_remote_idx_o = r_sig_idx;
    assign signal_state_o      = r_sig_state;
    assign signal_valid_o      = r_sig_valid;
    assign instr_data_o        = r_instr_data;
    assign instr_valid_o       = r_instr_valid;
    assign trigger_o           = r_trigger;

endmodule
